// File: rtl/write_pointer_ctrl_pkg.sv
// Shared definitions for the FIFO write/read pointer controllers:
// default widths, FSM state encoding and a Gray conversion helper.
package write_pointer_ctrl_pkg;

  localparam int ADDR_WIDTH_DEF = 2;
  localparam int DATA_WIDTH_DEF = 8;
  localparam int DROP_WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WRITING = 2'd1,
    STALLED = 2'd2
  } state_t;

  // Binary to reflected Gray code, for pointer widths up to 32 bits.
  function automatic logic [31:0] bin2gray(input logic [31:0] bin);
    return bin ^ (bin >> 1);
  endfunction

endpackage

// File: rtl/write_pointer_ctrl_gray_encoder.sv
// Combinational binary-to-Gray encoder, shared by both pointer controllers.
module gray_encoder #(
  parameter int WIDTH = 2
) (
  input  logic [WIDTH-1:0] bin,
  output logic [WIDTH-1:0] gray
);

  assign gray = bin ^ (bin >> 1);

endmodule

// File: rtl/write_pointer_ctrl.sv
// Write-side pointer controller of the synchronous FIFO.
// Handshake: the producer asserts write with wdata; the write is accepted on
// the same edge when full is low (accept = write & ~full). There is no ready
// output and no retry: a write seen while full is dropped, flagged in
// overflow and counted in drop_count. Accepted writes appear one cycle later
// on the RAM port together with write_ack and the advanced Gray pointer.
module write_pointer_ctrl
  import write_pointer_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int DROP_WIDTH = DROP_WIDTH_DEF
) (
  input  logic                  clk_write,
  input  logic                  reset,
  input  logic                  write,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  full,
  input  logic                  clr_overflow,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_waddr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [ADDR_WIDTH-1:0] write_pointer,
  output logic                  write_ack,
  output logic                  stall,
  output logic                  overflow,
  output logic [DROP_WIDTH-1:0] drop_count,
  output state_t                state
);

  logic [ADDR_WIDTH-1:0] bin_ptr;
  logic [ADDR_WIDTH-1:0] bin_next;
  logic [ADDR_WIDTH-1:0] gray_next;
  logic                  accept;
  logic                  drop;
  state_t                state_next;

  assign accept   = write & ~full;
  assign drop     = write & full;
  assign bin_next = bin_ptr + ADDR_WIDTH'(1);

  gray_encoder #(.WIDTH(ADDR_WIDTH)) u_gray_encoder (
    .bin  (bin_next),
    .gray (gray_next)
  );

  // Pointer and RAM-port registers: advance only on an accepted write.
  always_ff @(posedge clk_write) begin
    if (reset) begin
      bin_ptr       <= '0;
      write_pointer <= '0;
      mem_we        <= 1'b0;
      mem_waddr     <= '0;
      mem_wdata     <= '0;
      write_ack     <= 1'b0;
    end else begin
      mem_we    <= accept;
      write_ack <= accept;
      if (accept) begin
        mem_waddr     <= bin_ptr;
        mem_wdata     <= wdata;
        bin_ptr       <= bin_next;
        write_pointer <= gray_next;
      end
    end
  end

  // Sticky overflow and saturating drop counter; a same-cycle drop beats clear.
  always_ff @(posedge clk_write) begin
    if (reset) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (clr_overflow) begin
        drop_count <= DROP_WIDTH'(1);
      end else if (!(&drop_count)) begin
        drop_count <= drop_count + DROP_WIDTH'(1);
      end
    end else if (clr_overflow) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end
  end

  // FSM state register.
  always_ff @(posedge clk_write) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // FSM next state: every state follows the current request outcome.
  always_comb begin
    state_next = state;
    case (state)
      IDLE, WRITING, STALLED: begin
        if (accept) begin
          state_next = WRITING;
        end else if (drop) begin
          state_next = STALLED;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign stall = (state == STALLED);

endmodule

// File: tb/tb_write_pointer_ctrl.sv
// Directed and random checks of the FIFO write pointer controller.
module tb_write_pointer_ctrl;
  import write_pointer_ctrl_pkg::*;

  logic       clk_write = 1'b0;
  logic       reset;
  logic       write;
  logic [7:0] wdata;
  logic       full;
  logic       clr_overflow;
  logic       mem_we;
  logic [1:0] mem_waddr;
  logic [7:0] mem_wdata;
  logic [1:0] write_pointer;
  logic       write_ack;
  logic       stall;
  logic       overflow;
  logic [7:0] drop_count;
  state_t     state;

  int tests = 0;
  int fails = 0;

  // Clock and reset stimulus block
  always #5 clk_write = ~clk_write;

  write_pointer_ctrl #(
    .ADDR_WIDTH (2),
    .DATA_WIDTH (8),
    .DROP_WIDTH (8)
  ) dut (
    .clk_write     (clk_write),
    .reset         (reset),
    .write         (write),
    .wdata         (wdata),
    .full          (full),
    .clr_overflow  (clr_overflow),
    .mem_we        (mem_we),
    .mem_waddr     (mem_waddr),
    .mem_wdata     (mem_wdata),
    .write_pointer (write_pointer),
    .write_ack     (write_ack),
    .stall         (stall),
    .overflow      (overflow),
    .drop_count    (drop_count),
    .state         (state)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive inputs, take one clock edge, settle past it.
  task automatic step(input logic r, input logic w, input logic [7:0] d,
                      input logic f, input logic c);
    reset = r; write = w; wdata = d; full = f; clr_overflow = c;
    @(posedge clk_write);
    #1;
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_we"},    32'(mem_we), 0);
    chk({tag, "_waddr"}, 32'(mem_waddr), 0);
    chk({tag, "_wdata"}, 32'(mem_wdata), 0);
    chk({tag, "_wptr"},  32'(write_pointer), 0);
    chk({tag, "_ack"},   32'(write_ack), 0);
    chk({tag, "_stall"}, 32'(stall), 0);
    chk({tag, "_ovf"},   32'(overflow), 0);
    chk({tag, "_cnt"},   32'(drop_count), 0);
    chk({tag, "_state"}, 32'(state), 32'(IDLE));
  endtask

  task automatic chk_accept(input string tag, input int addr, input int gray, input int data);
    chk({tag, "_we"},    32'(mem_we), 1);
    chk({tag, "_ack"},   32'(write_ack), 1);
    chk({tag, "_waddr"}, 32'(mem_waddr), 32'(addr));
    chk({tag, "_wptr"},  32'(write_pointer), 32'(gray));
    chk({tag, "_wdata"}, 32'(mem_wdata), 32'(data));
    chk({tag, "_state"}, 32'(state), 32'(WRITING));
    chk({tag, "_stall"}, 32'(stall), 0);
  endtask

  // Scoreboard for the random phase
  logic [1:0] exp_q[$];
  logic [1:0] gtab [4];
  int         model_ptr;
  logic [1:0] prev_wp;
  int         accept_cnt;
  int         we_cnt;

  initial begin
    logic w, f;
    gtab[0] = 2'b00; gtab[1] = 2'b01; gtab[2] = 2'b11; gtab[3] = 2'b10;

    // 1. Reset held with write asserted
    for (int i = 0; i < 3; i++) step(1, 1, 8'h55, 0, 0);
    chk_idle_outputs("reset");

    // 2. Fill: four accepted writes
    step(0, 1, 8'hA0, 0, 0); chk_accept("fill0", 0, 1, 8'hA0);
    step(0, 1, 8'hA1, 0, 0); chk_accept("fill1", 1, 3, 8'hA1);
    step(0, 1, 8'hA2, 0, 0); chk_accept("fill2", 2, 2, 8'hA2);
    step(0, 1, 8'hA3, 0, 0); chk_accept("fill3", 3, 0, 8'hA3);

    // 3. Drops while full
    for (int i = 1; i <= 3; i++) begin
      step(0, 1, 8'hEE, 1, 0);
      chk("drop_we",    32'(mem_we), 0);
      chk("drop_ack",   32'(write_ack), 0);
      chk("drop_waddr", 32'(mem_waddr), 3);
      chk("drop_wdata", 32'(mem_wdata), 32'hA3);
      chk("drop_wptr",  32'(write_pointer), 0);
      chk("drop_ovf",   32'(overflow), 1);
      chk("drop_cnt",   32'(drop_count), 32'(i));
      chk("drop_stall", 32'(stall), 1);
      chk("drop_state", 32'(state), 32'(STALLED));
    end
    step(0, 1, 8'hB0, 0, 0); chk_accept("resume", 0, 1, 8'hB0);

    // 4. Saturation and clear
    for (int i = 0; i < 300; i++) step(0, 1, 8'h00, 1, 0);
    chk("sat_cnt",   32'(drop_count), 255);
    chk("sat_stall", 32'(stall), 1);
    chk("sat_wptr",  32'(write_pointer), 1);
    step(0, 0, 8'h00, 0, 1);
    chk("clr_ovf",   32'(overflow), 0);
    chk("clr_cnt",   32'(drop_count), 0);
    chk("clr_state", 32'(state), 32'(IDLE));
    chk("clr_we",    32'(mem_we), 0);
    step(0, 1, 8'h00, 1, 1);
    chk("clrset_ovf",   32'(overflow), 1);
    chk("clrset_cnt",   32'(drop_count), 1);
    chk("clrset_stall", 32'(stall), 1);

    // 5. Reset mid-burst
    step(0, 0, 8'h00, 0, 0);
    step(0, 1, 8'hC0, 0, 0); chk_accept("pre_rst", 1, 3, 8'hC0);
    step(1, 1, 8'hC5, 0, 0); chk_idle_outputs("mid_rst");
    step(0, 1, 8'hC1, 0, 0); chk_accept("post_rst", 0, 1, 8'hC1);

    // 6. Random traffic against a reference pointer model
    model_ptr = 1; prev_wp = 2'b01; accept_cnt = 0; we_cnt = 0;
    for (int i = 0; i < 10000; i++) begin
      w = 1'($urandom_range(0, 1));
      f = ($urandom_range(0, 3) == 0);
      if (w && !f) begin
        exp_q.push_back(2'(model_ptr));
        model_ptr = (model_ptr + 1) % 4;
        accept_cnt++;
      end
      step(0, w, 8'($urandom_range(0, 255)), f, 0);
      if (mem_we === 1'b1) we_cnt++;
      chk("rnd_we",    32'(mem_we), 32'(w && !f));
      chk("rnd_stall", 32'(stall), 32'(w && f));
      chk("rnd_wptr",  32'(write_pointer), 32'(gtab[model_ptr]));
      if (w && !f) begin
        chk("rnd_waddr", 32'(mem_waddr), 32'(exp_q.pop_front()));
        chk("rnd_gray1", $countones(prev_wp ^ write_pointer), 1);
      end
      prev_wp = write_pointer;
    end
    chk("rnd_we_count", 32'(we_cnt), 32'(accept_cnt));
    chk("rnd_queue_empty", 32'(exp_q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
